// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment scan driver.
// Segment codes here are active-high; output polarity is applied at the top level.
package seg_pkg;

  localparam int NUM_DIGITS = 4;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam logic [7:0] SEG_ALL_OFF = 8'h00;
  localparam logic [NUM_DIGITS-1:0] AN_ALL_OFF = '0;

  // {g..a} patterns for hex digits 0..F
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2,
    DIG3 = 2'd3
  } digit_state_e;

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dp;
    logic        blank;
  } disp_buf_t;

endpackage

// File: rtl/hex7seg_decode.sv
// Combinational nibble-to-segment decoder producing active-high {dp, g..a}.
module hex7seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  input  logic       dp,
  output logic [7:0] seg
);

  // A blanked digit loses a-g but still shows its decimal point.
  always_comb begin
    seg = SEG_ALL_OFF;
    if (!blank) begin
      seg[SEG_G:SEG_A] = HEX_SEG[nibble];
    end
    seg[SEG_DP] = dp;
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexes a 16-bit word onto a 4-digit seven-segment display.
// New values are double-buffered and committed only at the digit3 -> digit0 wrap.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV    = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value_i,
  input  logic [3:0]  dp_i,
  input  logic        blank_lz_i,
  input  logic        load_i,
  output logic [7:0]  seg_output_single,
  output logic [3:0]  seg_output_sequence,
  output logic        frame_done,
  output logic        pending_o
);

  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [7:0] SEG_OFF_OUT = SEG_ACTIVE_LOW ? ~SEG_ALL_OFF : SEG_ALL_OFF;
  localparam logic [3:0] AN_OFF_OUT  = SEG_ACTIVE_LOW ? ~AN_ALL_OFF  : AN_ALL_OFF;

  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic             wrap;
  digit_state_e     digit_idx;
  digit_state_e     digit_next;

  disp_buf_t        load_buf;
  disp_buf_t        pending_buf;
  disp_buf_t        shadow_buf;

  logic [3:0]       cur_nibble;
  logic [3:0]       lz_mask;
  logic             cur_blank;
  logic             cur_dp;
  logic [7:0]       seg_hi;
  logic [3:0]       an_hi;

  assign tick     = (div_cnt == DIV_LAST);
  assign wrap     = tick && (digit_idx == DIG3);
  assign load_buf = '{value: value_i, dp: dp_i, blank: blank_lz_i};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_idx <= DIG0;
    end else begin
      digit_idx <= digit_next;
    end
  end

  always_comb begin
    digit_next = digit_idx;
    if (tick) begin
      case (digit_idx)
        DIG0:    digit_next = DIG1;
        DIG1:    digit_next = DIG2;
        DIG2:    digit_next = DIG3;
        default: digit_next = DIG0;
      endcase
    end
  end

  // A load landing on the wrap cycle goes straight to the shadow so the newest value wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_buf <= '0;
      shadow_buf  <= '0;
      pending_o   <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= wrap;
      if (load_i) begin
        pending_buf <= load_buf;
      end
      if (load_i && wrap) begin
        shadow_buf <= load_buf;
        pending_o  <= 1'b0;
      end else if (load_i) begin
        pending_o  <= 1'b1;
      end else if (wrap && pending_o) begin
        shadow_buf <= pending_buf;
        pending_o  <= 1'b0;
      end
    end
  end

  // lz_mask[n] is set when nibble n and every higher nibble are zero; digit0 never blanks.
  always_comb begin
    lz_mask    = '0;
    lz_mask[3] = (shadow_buf.value[15:12] == 4'h0);
    lz_mask[2] = lz_mask[3] && (shadow_buf.value[11:8] == 4'h0);
    lz_mask[1] = lz_mask[2] && (shadow_buf.value[7:4] == 4'h0);
    cur_nibble = shadow_buf.value[{digit_idx, 2'b00} +: 4];
    cur_blank  = shadow_buf.blank && lz_mask[digit_idx];
    cur_dp     = shadow_buf.dp[digit_idx];
    an_hi      = 4'b0001 << digit_idx;
  end

  hex7seg_decode u_decode (
    .nibble (cur_nibble),
    .blank  (cur_blank),
    .dp     (cur_dp),
    .seg    (seg_hi)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_output_single   <= SEG_OFF_OUT;
      seg_output_sequence <= AN_OFF_OUT;
    end else begin
      seg_output_single   <= SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
      seg_output_sequence <= SEG_ACTIVE_LOW ? ~an_hi  : an_hi;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: scans whole frames and checks every held cycle.
module tb_seg_scan_driver;

  logic        clk;
  logic        rst;
  logic [15:0] value_i;
  logic [3:0]  dp_i;
  logic        blank_lz_i;
  logic        load_i;
  logic [7:0]  seg_output_single;
  logic [3:0]  seg_output_sequence;
  logic        frame_done;
  logic        pending_o;

  int passCount;
  int checkCount;
  int failCount;
  logic pendExp;
  logic [3:0] anTab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  seg_scan_driver #(.REFRESH_DIV(2), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .value_i             (value_i),
    .dp_i                (dp_i),
    .blank_lz_i          (blank_lz_i),
    .load_i              (load_i),
    .seg_output_single   (seg_output_single),
    .seg_output_sequence (seg_output_sequence),
    .frame_done          (frame_done),
    .pending_o           (pending_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int frameId, input int step,
                             input logic [7:0] observed, input logic [7:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s frame %0d step %0d: got %h, want %h", tag, frameId, step, observed, expected);
    end
  endtask

  // Scans one frame from a frame start (8 held cycles), optionally loading on given steps.
  task automatic applyStimulus(input int frameId,
                               input int ld1Step, input logic [15:0] ld1Val,
                               input logic [3:0] ld1Dp, input logic ld1Blank,
                               input int ld2Step, input logic [15:0] ld2Val,
                               input logic [7:0] e0, input logic [7:0] e1,
                               input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] segTab [4];
    logic loaded;
    segTab = '{e0, e1, e2, e3};
    for (int k = 0; k < 8; k++) begin
      loaded = 1'b0;
      if (k == ld1Step) begin
        value_i = ld1Val; dp_i = ld1Dp; blank_lz_i = ld1Blank; load_i = 1'b1; loaded = 1'b1;
      end else if (k == ld2Step) begin
        value_i = ld2Val; dp_i = 4'h0; blank_lz_i = 1'b0; load_i = 1'b1; loaded = 1'b1;
      end
      @(negedge clk);
      load_i = 1'b0;
      if (loaded) pendExp = (k != 7);
      else if (k == 7) pendExp = 1'b0;
      checkOutput("seg", frameId, k, seg_output_single, segTab[k/2]);
      checkOutput("anode", frameId, k, {4'h0, seg_output_sequence}, {4'h0, anTab[k/2]});
      checkOutput("frame_done", frameId, k, {7'h0, frame_done}, {7'h0, (k == 7)});
      checkOutput("pending", frameId, k, {7'h0, pending_o}, {7'h0, pendExp});
    end
  endtask

  initial begin
    passCount  = 0;
    checkCount = 0;
    failCount  = 0;
    pendExp    = 1'b0;
    value_i    = 16'h0;
    dp_i       = 4'h0;
    blank_lz_i = 1'b0;
    load_i     = 1'b0;
    rst        = 1'b1;

    repeat (2) @(negedge clk);
    checkOutput("rst_seg", 0, 0, seg_output_single, 8'hFF);
    checkOutput("rst_anode", 0, 0, {4'h0, seg_output_sequence}, 8'h0F);
    checkOutput("rst_frame_done", 0, 0, {7'h0, frame_done}, 8'h00);
    checkOutput("rst_pending", 0, 0, {7'h0, pending_o}, 8'h00);
    rst = 1'b0;

    $display("[TB] scan after reset, shadow zero");
    applyStimulus(0, -1, 16'h0, 4'h0, 1'b0, -1, 16'h0, 8'hC0, 8'hC0, 8'hC0, 8'hC0);

    $display("[TB] load 12AF mid-frame");
    applyStimulus(1, 2, 16'h12AF, 4'h0, 1'b0, -1, 16'h0, 8'hC0, 8'hC0, 8'hC0, 8'hC0);

    $display("[TB] show 12AF, load 0005 with blanking and dp1");
    applyStimulus(2, 3, 16'h0005, 4'b0010, 1'b1, -1, 16'h0, 8'h8E, 8'h88, 8'hA4, 8'hF9);

    $display("[TB] show 0005 blanked, double load 1111 then 2222");
    applyStimulus(3, 1, 16'h1111, 4'h0, 1'b0, 4, 16'h2222, 8'h92, 8'h7F, 8'hFF, 8'hFF);

    $display("[TB] show 2222, load BEEF on the wrap cycle");
    applyStimulus(4, 7, 16'hBEEF, 4'h0, 1'b0, -1, 16'h0, 8'hA4, 8'hA4, 8'hA4, 8'hA4);

    $display("[TB] show BEEF");
    applyStimulus(5, -1, 16'h0, 4'h0, 1'b0, -1, 16'h0, 8'h8E, 8'h86, 8'h86, 8'h83);

    $display("[TB] reset while digit2 is selected");
    repeat (4) @(negedge clk);
    checkOutput("pre_rst_anode", 6, 4, {4'h0, seg_output_sequence}, {4'h0, anTab[1]});
    #1 rst = 1'b1;
    #1;
    checkOutput("mid_rst_seg", 6, 4, seg_output_single, 8'hFF);
    checkOutput("mid_rst_anode", 6, 4, {4'h0, seg_output_sequence}, 8'h0F);
    checkOutput("mid_rst_frame_done", 6, 4, {7'h0, frame_done}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    pendExp = 1'b0;
    applyStimulus(7, -1, 16'h0, 4'h0, 1'b0, -1, 16'h0, 8'hC0, 8'hC0, 8'hC0, 8'hC0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
Downstream display stage of the LC3 core. It takes the 16-bit word selected for display and time-multiplexes it as four hex digits onto the board's 4-digit seven-segment display, driving seg_output_single and seg_output_sequence. New values are double-buffered and committed only at frame boundaries, so a digit is never shown half-updated.

Parameters:
REFRESH_DIV, 2, clock cycles each digit is held; must be >= 1 (1 = advance every cycle).
SEG_ACTIVE_LOW, 1, 1 = segment and anode outputs active-low; 0 = active-high (inverts both buses).

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
value_i  input  16  word to display; digit0 = value_i[3:0] ... digit3 = value_i[15:12]
dp_i  input  4  decimal-point enable per digit, bit n = digit n
blank_lz_i  input  1  leading-zero blanking enable, captured with load_i
load_i  input  1  single-cycle strobe; captures value_i/dp_i/blank_lz_i into the pending buffer
seg_output_single  output  8  segment bus, bit0..6 = a..g, bit7 = dp
seg_output_sequence  output  4  digit anodes, one-hot (one-cold when active-low)
frame_done  output  1  one-cycle pulse when digit3 -> digit0 wrap commits
pending_o  output  1  high while a loaded value awaits commit

Behaviour:
- Reset (async, immediate, also mid-frame): div_cnt=0, digit_idx=0, shadow and pending buffers=0, pending_o=0, frame_done=0, all segments off (8'hFF), all anodes off (4'hF) for active-low.
- Divider: div_cnt counts 0..REFRESH_DIV-1. tick = (div_cnt==REFRESH_DIV-1). On tick, div_cnt clears and digit_idx advances 0->1->2->3->0.
- wrap = tick && digit_idx==3. frame_done is registered and high for exactly the cycle after wrap.
- load_i: pending <= {value_i, dp_i, blank_lz_i}; pending_o <= 1. Back-to-back loads: the last one wins.
- On wrap with pending_o=1: shadow <= pending; pending_o <= 0.
- Simultaneous load_i and wrap: shadow <= current load_i inputs directly (newest wins); pending_o <= 0.
- Outputs are registered, computed from the current digit_idx and shadow. They change one cycle after digit_idx changes.
- Anode code (active-low): digit0 = 4'b1110, digit1 = 4'b1101, digit2 = 4'b1011, digit3 = 4'b0111. Exactly one anode is active at any time after the first post-reset edge.
- Hex decode, active-high {g..a}: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- Active-low output is the bitwise inverse, e.g. '0' -> 8'hC0 and 'A' -> 8'h88 (dp off).
- Leading-zero blanking: if the shadow blank bit is set, digit n (n = 3,2,1) is blanked when its nibble and all higher nibbles are zero. Digit0 is never blanked.
- A blanked digit drives a-g off. Its dp still follows the shadow dp bit.
- dp: bit7 is active when the shadow dp[n] = 1 for the digit being shown.

Decomposition:
- Shared package seg_pkg holds:
  - NUM_DIGITS = 4
  - segment bit-position constants A..G and DP
  - the 16-entry hex-to-segment constant table
  - the all-off constants
- One combinational sub-module, hex7seg_decode (nibble, blank, dp -> 8-bit active-high segments). Polarity inversion is applied in seg_scan_driver.
- seg_scan_driver contains the divider, the digit FSM (4 states, one per digit), the pending/shadow buffers and the output registers.

Test Plan:
- Reset held, then released with REFRESH_DIV=2: segments=8'hFF and anodes=4'hF during reset. After release, anodes cycle 1110,1101,1011,0111 with each held 2 cycles.
- load value_i=16'h12AF, dp_i=0: after the next frame_done, digit0..3 show 8E(F), 88(A), A4(2), F9(1).
- load 16'h0005 with blank_lz_i=1, dp_i=4'b0010: digits 3 and 2 show 8'hFF; digit1 shows 8'h7F (blank, dp on); digit0 shows 8'h92.
- Two loads mid-frame (16'h1111 then 16'h2222): pending_o stays high until wrap, and only 2222 is ever displayed. No digit shows 1 in that frame.
- load_i asserted in the exact wrap cycle with 16'hBEEF: the next frame shows BEEF, pending_o=0, and frame_done pulses once.
- rst asserted while digit_idx=2: outputs go to all-off asynchronously. After release, scanning restarts at digit0 and the shadow value is 0.
